// File: rtl/tx_sched_pkg.sv
// Shared types and helpers for the TX descriptor scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    S_ARB,
    S_WAIT,
    S_REQ
  } sched_state_t;

  // Widest descriptor word the split helpers handle.
  localparam int unsigned DESC_MAX_W = 128;

  typedef logic [DESC_MAX_W-1:0] desc_word_t;

  // Address field sits in the low addr_w bits of the descriptor.
  function automatic desc_word_t desc_addr(input desc_word_t desc,
                                           input int unsigned addr_w);
    desc_word_t mask;
    mask = (desc_word_t'(1) << addr_w) - desc_word_t'(1);
    return desc & mask;
  endfunction

  // Length field sits directly above the address field.
  function automatic desc_word_t desc_len(input desc_word_t desc,
                                          input int unsigned addr_w,
                                          input int unsigned len_w);
    desc_word_t mask;
    mask = (desc_word_t'(1) << len_w) - desc_word_t'(1);
    return (desc >> addr_w) & mask;
  endfunction

endpackage

// File: rtl/tx_sched_arbiter.sv
// Combinational flow picker for the TX descriptor scheduler.
// Default: round-robin starting at ptr.
// TX_SCHED_PRIO_EN defined: fixed priority, lowest eligible index wins.
module tx_sched_arbiter #(
  parameter int unsigned FLOWS = 4,
  parameter int unsigned FW    = 2
) (
  input  logic [FLOWS-1:0] eligible,
  input  logic [FW-1:0]    ptr,
  output logic             any,
  output logic [FW-1:0]    grant
);

  logic [FW-1:0] idx;

  // First eligible flow in search order.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < FLOWS; k++) begin
`ifdef TX_SCHED_PRIO_EN
      idx = FW'(k);
`else
      idx = FW'((32'(ptr) + k) % FLOWS);
`endif
      if (!any && eligible[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/tx_desc_sched.sv
// Multi-flow TX descriptor scheduler: arbitrates among running flows,
// reads one descriptor, issues the DMA request and tracks per-flow
// outstanding transfers so IDLE only rises once a flow is drained.
// Optional: TX_SCHED_PRIO_EN selects fixed-priority arbitration.
module tx_desc_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned FLOWS      = 4,
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned DESC_WIDTH = ADDR_WIDTH + LEN_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [FLOWS-1:0]           RUN,
  output logic [FLOWS-1:0]           IDLE,
  input  logic [FLOWS-1:0]           DESC_EMPTY,
  output logic                       DESC_READ,
  output logic [$clog2(FLOWS)-1:0]   DESC_ADDR,
  input  logic [DESC_WIDTH-1:0]      DESC_DO,
  input  logic                       DESC_DO_VLD,
  input  logic [FLOWS-1:0]           SU_HFULL,
  output logic                       DMA_REQ,
  input  logic                       DMA_ACK,
  output logic [ADDR_WIDTH-1:0]      DMA_ADDR,
  output logic [LEN_WIDTH-1:0]       DMA_LEN,
  output logic [$clog2(FLOWS)-1:0]   DMA_FLOW,
  input  logic                       DMA_DONE,
  input  logic [$clog2(FLOWS)-1:0]   DMA_DONE_FLOW
);

  localparam int unsigned FW = $clog2(FLOWS);
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  sched_state_t          state, state_nx;
  logic [FW-1:0]         cur, ptr, grant;
  logic                  any;
  logic [FLOWS-1:0]      eligible, ack_hit, done_hit;
  logic [CW-1:0]         outst [FLOWS];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;

  assign addr_d = ADDR_WIDTH'(desc_addr(desc_word_t'(DESC_DO), ADDR_WIDTH));
  assign len_d  = LEN_WIDTH'(desc_len(desc_word_t'(DESC_DO), ADDR_WIDTH, LEN_WIDTH));

  // Per-flow eligibility plus counter update strobes and drained status.
  always_comb begin
    eligible = '0;
    ack_hit  = '0;
    done_hit = '0;
    IDLE     = '0;
    for (int unsigned i = 0; i < FLOWS; i++) begin
      eligible[i] = RUN[i] && !DESC_EMPTY[i] && !SU_HFULL[i] &&
                    (outst[i] < CW'(MAX_OUTST));
      ack_hit[i]  = DMA_REQ && DMA_ACK && (cur == FW'(i));
      done_hit[i] = DMA_DONE && (DMA_DONE_FLOW == FW'(i));
      IDLE[i]     = !RUN[i] && (outst[i] == '0) &&
                    !((state != S_ARB) && (cur == FW'(i)));
    end
  end

  tx_sched_arbiter #(
    .FLOWS (FLOWS),
    .FW    (FW)
  ) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .any      (any),
    .grant    (grant)
  );

  // Next-state and strobe decode.
  always_comb begin
    state_nx  = state;
    DESC_READ = 1'b0;
    case (state)
      S_ARB: begin
        if (any && !RESET) begin
          DESC_READ = 1'b1;
          state_nx  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DESC_DO_VLD) state_nx = (len_d == '0) ? S_ARB : S_REQ;
      end
      S_REQ: begin
        if (DMA_ACK) state_nx = S_ARB;
      end
      default: state_nx = S_ARB;
    endcase
  end

  assign DESC_ADDR = grant;
  assign DMA_REQ   = (state == S_REQ);
  assign DMA_ADDR  = addr_q;
  assign DMA_LEN   = len_q;
  assign DMA_FLOW  = cur;

  // State, granted flow, round-robin pointer and latched descriptor.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_ARB;
      cur    <= '0;
      ptr    <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      state <= state_nx;
      if (DESC_READ) begin
        cur <= grant;
        ptr <= (grant == FW'(FLOWS - 1)) ? '0 : grant + FW'(1);
      end
      if (state == S_WAIT && DESC_DO_VLD) begin
        addr_q <= addr_d;
        len_q  <= len_d;
      end
    end
  end

  // Outstanding counters: ack and done on the same flow cancel, done saturates at 0.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < FLOWS; i++) begin
      if (RESET) begin
        outst[i] <= '0;
      end else if (ack_hit[i] && !done_hit[i]) begin
        outst[i] <= outst[i] + CW'(1);
      end else if (done_hit[i] && !ack_hit[i] && outst[i] != '0) begin
        outst[i] <= outst[i] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_desc_sched.sv
// Self-checking bench for tx_desc_sched (round-robin build, MAX_OUTST=2).
module tb_tx_desc_sched;

  localparam int MAXO = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  RUN, IDLE, DESC_EMPTY, SU_HFULL;
  logic        DESC_READ;
  logic [1:0]  DESC_ADDR;
  logic [63:0] DESC_DO;
  logic        DESC_DO_VLD;
  logic        DMA_REQ, DMA_ACK, DMA_DONE;
  logic [47:0] DMA_ADDR;
  logic [15:0] DMA_LEN;
  logic [1:0]  DMA_FLOW, DMA_DONE_FLOW;

  tx_desc_sched #(
    .FLOWS      (4),
    .ADDR_WIDTH (48),
    .LEN_WIDTH  (16),
    .MAX_OUTST  (MAXO)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .RUN           (RUN),
    .IDLE          (IDLE),
    .DESC_EMPTY    (DESC_EMPTY),
    .DESC_READ     (DESC_READ),
    .DESC_ADDR     (DESC_ADDR),
    .DESC_DO       (DESC_DO),
    .DESC_DO_VLD   (DESC_DO_VLD),
    .SU_HFULL      (SU_HFULL),
    .DMA_REQ       (DMA_REQ),
    .DMA_ACK       (DMA_ACK),
    .DMA_ADDR      (DMA_ADDR),
    .DMA_LEN       (DMA_LEN),
    .DMA_FLOW      (DMA_FLOW),
    .DMA_DONE      (DMA_DONE),
    .DMA_DONE_FLOW (DMA_DONE_FLOW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: descriptor queues, outstanding counts, the one
  // descriptor in flight and the round-robin start point.
  typedef struct packed {
    logic [15:0] len;
    logic [47:0] addr;
  } desc_t;

  desc_t dq [4][$];
  int    cnt [4];
  int    ptr_m, bflow, wait_left, cyc;
  bit    busy, req_pend;
  desc_t bdesc;
  int    grant_log[$], req_log[$], cyc_log[$];

  logic [3:0] run_v, hfull_v;
  int  ack_pct, done_pct, vld_min, vld_max, force_done;
  bit  rand_hfull, spur_vld, done_with_ack3;

  function automatic desc_t mk(input int len);
    desc_t d;
    d.len  = 16'(len);
    d.addr = 48'({$urandom, $urandom});
    return d;
  endfunction

  function automatic int pick();
    for (int k = 0; k < 4; k++) begin
      int f;
      f = (ptr_m + k) % 4;
      if (RUN[f] && dq[f].size() > 0 && !SU_HFULL[f] && cnt[f] < MAXO) return f;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    ptr_m = 0; busy = 0; req_pend = 0;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) dq[i].delete();
    grant_log.delete(); req_log.delete(); cyc_log.delete();
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model.
  task automatic cycle();
    int g, dflow;
    bit vld_now, ack_now, done_now;
    RUN      = run_v;
    SU_HFULL = rand_hfull ? 4'($urandom_range(0, 15) & $urandom_range(0, 15)) : hfull_v;
    for (int i = 0; i < 4; i++) DESC_EMPTY[i] = (dq[i].size() == 0);
    vld_now     = 0;
    DESC_DO_VLD = 1'b0;
    DESC_DO     = {$urandom, $urandom};
    if (busy && !req_pend) begin
      wait_left--;
      if (wait_left == 0) begin
        vld_now = 1; DESC_DO_VLD = 1'b1; DESC_DO = bdesc;
      end
    end else if (spur_vld && $urandom_range(0, 3) == 0) begin
      DESC_DO_VLD = 1'b1;
    end
    ack_now = req_pend && ($urandom_range(0, 99) < ack_pct);
    DMA_ACK = ack_now;
    done_now = 0; dflow = 0;
    if (force_done >= 0) begin
      done_now = 1; dflow = force_done; force_done = -1;
    end else if (done_with_ack3 && ack_now && bflow == 3) begin
      done_now = 1; dflow = 3;
    end else if ($urandom_range(0, 99) < done_pct) begin
      done_now = 1; dflow = $urandom_range(0, 3);
    end
    DMA_DONE      = done_now;
    DMA_DONE_FLOW = 2'(dflow);
    @(negedge CLK);
    if (RESET) begin
      model_reset();
    end else begin
      g = busy ? -1 : pick();
      chk("desc_read", 64'(DESC_READ), 64'(g >= 0));
      if (g >= 0) chk("desc_addr", 64'(DESC_ADDR), 64'(g));
      chk("dma_req", 64'(DMA_REQ), 64'(req_pend));
      if (req_pend) begin
        chk("dma_flow", 64'(DMA_FLOW), 64'(bflow));
        chk("dma_addr", 64'(DMA_ADDR), 64'(bdesc.addr));
        chk("dma_len", 64'(DMA_LEN), 64'(bdesc.len));
      end
      for (int i = 0; i < 4; i++)
        chk($sformatf("idle%0d", i), 64'(IDLE[i]),
            64'(!RUN[i] && cnt[i] == 0 && !(busy && bflow == i)));
      if (ack_now) begin
        cnt[bflow]++; req_pend = 0; busy = 0; req_log.push_back(bflow);
      end
      if (vld_now) begin
        if (bdesc.len == 0) busy = 0; else req_pend = 1;
      end
      if (done_now && cnt[dflow] > 0) cnt[dflow]--;
      if (g >= 0) begin
        busy = 1; bflow = g; bdesc = dq[g].pop_front(); ptr_m = (g + 1) % 4;
        wait_left = $urandom_range(vld_min, vld_max);
        grant_log.push_back(g); cyc_log.push_back(cyc);
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    clear_logs();
  endtask

  initial begin
    run_v = '0; hfull_v = '0; ack_pct = 100; done_pct = 0;
    vld_min = 1; vld_max = 1; force_done = -1;
    rand_hfull = 0; spur_vld = 0; done_with_ack3 = 0;
    cyc = 0; bflow = 0; wait_left = 0; bdesc = '0;
    model_reset(); clear_logs();
    RESET = 1'b1; RUN = '0; DESC_EMPTY = '1; SU_HFULL = '0; DESC_DO = '0;
    DESC_DO_VLD = 1'b0; DMA_ACK = 1'b0; DMA_DONE = 1'b0; DMA_DONE_FLOW = '0;
    @(posedge CLK); #1;

    // Reset values
    run_v = 4'b0110;
    do_reset();
    chk("rst_desc_read", 64'(DESC_READ), 64'(0));
    chk("rst_dma_req", 64'(DMA_REQ), 64'(0));
    chk("rst_dma_addr", 64'(DMA_ADDR), 64'(0));
    chk("rst_dma_len", 64'(DMA_LEN), 64'(0));
    chk("rst_dma_flow", 64'(DMA_FLOW), 64'(0));
    chk("rst_idle", 64'(IDLE), 64'(4'b1001));

    // All flows running, immediate acks: 0,1,2,3,0
    run_v = 4'hF;
    dq[0].push_back(mk($urandom_range(1, 1500)));
    dq[0].push_back(mk($urandom_range(1, 1500)));
    for (int i = 1; i < 4; i++) dq[i].push_back(mk($urandom_range(1, 1500)));
    run_cycles(20);
    chk("rr_reads", 64'(grant_log.size()), 64'(5));
    chk("rr_reqs", 64'(req_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_seq", 64'(grant_log[i]), 64'(i % 4));
    for (int i = 0; i < 5 && i < req_log.size(); i++) chk("rr_req_flow", 64'(req_log[i]), 64'(i % 4));
    if (cyc_log.size() >= 2) chk("loop_cycles", 64'(cyc_log[1] - cyc_log[0]), 64'(3));
    run_v = '0;
    for (int i = 0; i < 6; i++) begin
      force_done = (i < 2) ? 0 : ((i < 5) ? i - 1 : 0);
      cycle();
    end
    chk("drained_idle", 64'(IDLE), 64'(4'hF));

    // Flow 1 status buffer half full: 0,2,3,0 then 1 once released
    do_reset();
    run_v = 4'hF; hfull_v = 4'b0010;
    dq[0].push_back(mk(64)); dq[0].push_back(mk(128));
    for (int i = 1; i < 4; i++) dq[i].push_back(mk(256));
    run_cycles(20);
    chk("hfull_reads", 64'(grant_log.size()), 64'(4));
    if (grant_log.size() == 4) begin
      chk("hfull_g0", 64'(grant_log[0]), 64'(0));
      chk("hfull_g1", 64'(grant_log[1]), 64'(2));
      chk("hfull_g2", 64'(grant_log[2]), 64'(3));
      chk("hfull_g3", 64'(grant_log[3]), 64'(0));
    end
    hfull_v = '0;
    run_cycles(8);
    chk("hfull_release", 64'(grant_log.size()), 64'(5));
    if (grant_log.size() == 5) chk("hfull_g4", 64'(grant_log[4]), 64'(1));

    // In-flight limit on flow 2
    do_reset();
    run_v = 4'b0100;
    for (int i = 0; i < 3; i++) dq[2].push_back(mk(100 + i));
    run_cycles(20);
    chk("outst_stall_reads", 64'(grant_log.size()), 64'(2));
    chk("outst_stall_reqs", 64'(req_log.size()), 64'(2));
    force_done = 2;
    run_cycles(10);
    chk("outst_resume", 64'(grant_log.size()), 64'(3));
    if (grant_log.size() == 3) chk("outst_resume_flow", 64'(grant_log[2]), 64'(2));

    // Zero-length descriptor on flow 0 is dropped
    do_reset();
    run_v = 4'hF;
    dq[0].push_back(mk(0)); dq[1].push_back(mk(512));
    run_cycles(15);
    chk("zlen_reads", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) chk("zlen_next", 64'(grant_log[1]), 64'(1));
    chk("zlen_reqs", 64'(req_log.size()), 64'(1));
    if (req_log.size() == 1) chk("zlen_req_flow", 64'(req_log[0]), 64'(1));

    // Ack and done on flow 3 in the same cycle
    do_reset();
    run_v = 4'b1000;
    dq[3].push_back(mk(40));
    run_cycles(8);
    dq[3].push_back(mk(80));
    done_with_ack3 = 1;
    run_cycles(8);
    done_with_ack3 = 0;
    run_v = '0;
    cycle();
    chk("ackdone_idle_low", 64'(IDLE[3]), 64'(0));
    force_done = 3;
    cycle();
    chk("ackdone_idle_high", 64'(IDLE[3]), 64'(1));

    // Reset while a request is pending
    do_reset();
    run_v = 4'hF;
    dq[1].push_back(mk(33)); dq[3].push_back(mk(44));
    run_cycles(10);
    ack_pct = 0;
    dq[2].push_back(mk(55));
    for (int k = 0; k < 10 && !req_pend; k++) cycle();
    chk("pre_rst_req", 64'(DMA_REQ), 64'(1));
    run_v = 4'b0101;
    do_reset();
    chk("mid_rst_req", 64'(DMA_REQ), 64'(0));
    chk("mid_rst_idle", 64'(IDLE), 64'(4'b1010));
    ack_pct = 100; force_done = 1; run_v = 4'hF;
    for (int i = 0; i < 4; i++) dq[i].push_back(mk(60));
    run_cycles(6);
    if (grant_log.size() > 0) chk("mid_rst_restart", 64'(grant_log[0]), 64'(0));
    else chk("mid_rst_restart", 64'(grant_log.size()), 64'(1));

    // Randomized traffic against the model
    do_reset();
    ack_pct = 60; done_pct = 25; vld_min = 1; vld_max = 3;
    spur_vld = 1; rand_hfull = 1;
    for (int k = 0; k < 1500; k++) begin
      if (k % 40 == 0) run_v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        int f;
        f = $urandom_range(0, 3);
        if (dq[f].size() < 4)
          dq[f].push_back(mk(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 65535)));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_desc_sched.md
# tx_desc_sched

Multi-flow descriptor scheduler for the packet TX DMA controller. Picks, among `FLOWS` channels, one that is running, has a descriptor available and free status-update space, and reads that descriptor. It then issues the DMA request and keeps a per-flow count of outstanding transfers, so a flow's `IDLE` is reported only when nothing is in flight. It sits between the descriptor manager and status update unit on one side and the DMA engine on the other, and generalises the single-request TX controller to configurable flow count, descriptor format and in-flight depth.

## Interface
- `FLOWS`, 4, number of channels (≥2)
- `ADDR_WIDTH`, 48, DMA address bits
- `LEN_WIDTH`, 16, transfer length bits
- `MAX_OUTST`, 4, maximum outstanding DMA requests per flow (≥1)
- `DESC_WIDTH`, `ADDR_WIDTH+LEN_WIDTH`, descriptor word; `{len, addr}`, with the address in the low bits
- `CLK`  in  1  clock; one clock domain
- `RESET`  in  1  synchronous, active-high reset
- `RUN`  in  FLOWS  flow enabled by software
- `IDLE`  out  FLOWS  flow stopped and drained
- `DESC_EMPTY`  in  FLOWS  no descriptor available for the flow
- `DESC_READ`  out  1  descriptor read strobe
- `DESC_ADDR`  out  clog2(FLOWS)  flow being read
- `DESC_DO`  in  DESC_WIDTH  descriptor data
- `DESC_DO_VLD`  in  1  descriptor data valid
- `SU_HFULL`  in  FLOWS  status-update buffer half full
- `DMA_REQ`  out  1  transfer request
- `DMA_ACK`  in  1  request accepted
- `DMA_ADDR`  out  ADDR_WIDTH  transfer address
- `DMA_LEN`  out  LEN_WIDTH  transfer length in bytes
- `DMA_FLOW`  out  clog2(FLOWS)  owning flow
- `DMA_DONE`  in  1  transfer finished
- `DMA_DONE_FLOW`  in  clog2(FLOWS)  flow of the finished transfer

## Operation
- A flow is **eligible** when all of these hold: `RUN[i]`, `!DESC_EMPTY[i]`, `!SU_HFULL[i]`, and `outst[i] < MAX_OUTST`.
- FSM has three states: `S_ARB`, `S_WAIT`, `S_REQ`.
- **S_ARB**
  - If any flow is eligible: drive `DESC_READ=1` and `DESC_ADDR=grant` in this cycle, store `grant` in `cur`, then go to `S_WAIT`.
  - Otherwise stay in `S_ARB`.
- **Arbitration**: round-robin starting from `ptr`. On a grant, `ptr <= grant+1`, wrapping to 0 after `FLOWS-1`.
- **S_WAIT**: wait for `DESC_DO_VLD`, then latch `addr` and `len`.
  - `len==0`: drop the descriptor and return to `S_ARB`. No request is issued and no counter changes.
  - Otherwise go to `S_REQ`.
- **S_REQ**: hold `DMA_REQ=1` with stable `DMA_ADDR`, `DMA_LEN` and `DMA_FLOW=cur` until `DMA_ACK`. On the ack, `outst[cur]++` and return to `S_ARB`.
- **Counters**
  - `DMA_DONE` decrements `outst[DMA_DONE_FLOW]`.
  - An ack and a done for the same flow in the same cycle leave the counter unchanged.
  - A done on a flow whose counter is 0 is ignored (saturates at 0).
- **IDLE**: `IDLE[i] = !RUN[i] && outst[i]==0 && !(state!=S_ARB && cur==i)`.
- **Invariants**
  - `DESC_READ` never occurs for flow i while `SU_HFULL[i]` or `IDLE[i]` is high.
  - `DMA_REQ` never occurs for a flow whose `IDLE` is high.
- Deasserting `RUN` during `S_WAIT`/`S_REQ` does not abort. The current descriptor completes and the flow becomes ineligible afterwards.

## Timing
- `DESC_READ` is combinational from registered state and the current eligibility inputs. It is a one-cycle pulse; it is not asserted again until the FSM is back in `S_ARB`.
- `DESC_DO_VLD` arrives no earlier than 1 cycle after `DESC_READ`. A `DESC_DO_VLD` seen outside `S_WAIT` is ignored.
- `DMA_REQ` rises on the cycle after `DESC_DO_VLD`.
- An ack in the first cycle of `S_REQ` gives the minimum loop: arbitration, read, valid, request, next arbitration, i.e. 3 cycles per descriptor when valid arrives on the next cycle.
- Reset values:
  - `DESC_READ=0`, `DMA_REQ=0`.
  - `DMA_ADDR`, `DMA_LEN`, `DMA_FLOW` = 0.
  - All counters 0, `ptr=0`, state `S_ARB`.
  - `IDLE` = `~RUN`.
- Reset mid-operation: the FSM returns to `S_ARB` and `DMA_REQ` is low on the next edge. Outstanding counts are cleared, and `DMA_DONE` pulses that follow the reset are ignored by saturation.

## Configuration
- `TX_SCHED_PRIO_EN` defined: fixed priority, lowest eligible index wins, `ptr` is unused. Flow 0 can starve the others.
- `TX_SCHED_PRIO_EN` undefined: round-robin as described above.
- The port list is identical in both cases.

## Structure
- Package `tx_sched_pkg` holds:
  - the state enum `sched_state_t`
  - a function `desc_len(desc)` and a function `desc_addr(desc)` that split a descriptor word
- Sub-module `tx_sched_arbiter`: a combinational round-robin/priority picker, with inputs `eligible` and `ptr`, and outputs `any` and `grant`.

## Test plan
- FLOWS=4, flows 0–3 running with descriptors, acks immediate → `DESC_ADDR` sequence 0,1,2,3,0; one `DMA_REQ` per read, with the matching `DMA_FLOW`.
- `SU_HFULL[1]=1` → flow 1 is never read and the others continue: sequence 0,2,3,0.
- MAX_OUTST=2, flow 2 only, no `DMA_DONE` → exactly 2 requests, then stall; one `DMA_DONE` with flow 2 → a third read follows.
- Descriptor with `len=0` on flow 0 → no `DMA_REQ`; the next grant is flow 1.
- `DMA_ACK` and `DMA_DONE` for flow 3 in the same cycle with `outst=1` → it stays 1. With `RUN[3]=0`, `IDLE[3]` rises only after the final done.
- `RESET` asserted while `DMA_REQ=1` → `DMA_REQ=0` on the next cycle, all flows with `RUN=0` report `IDLE`, and arbitration restarts at flow 0.
